rx_word_fifo: RTL and testbench

Upstream feeder for the RAM program loader. Packs the serial receiver's byte stream into little-endian 32-bit words and buffers them in a DEPTH-word FIFO. Serves the words through the loader's read-enable / acknowledge handshake (`empty_ni`, `read_enable_o`, `rx_ack_i`, `data_in` on the loader side). Flushes partial trailing words after an idle timeout and flags dropped words on overflow.

---
 rtl/ram_loader_pkg.sv | 11 +
 rtl/fifo_mem.sv | 34 +++
 rtl/rx_word_fifo.sv | 154 +++++++++++++++
 tb/tb_rx_word_fifo.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_loader_pkg.sv
// Shared word/byte geometry and read-handshake states for the RAM program loader path.
package ram_loader_pkg;
  localparam int WORD_W         = 32;
  localparam int BYTE_W         = 8;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } rd_state_e;
endpackage

// File: rtl/fifo_mem.sv
// Word storage for rx_word_fifo: one write port, one registered read port whose
// output holds the last read word until the next read.
module fifo_mem
  import ram_loader_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk_sys,
  input  logic              rst_sys_n,
  input  logic              wr_en_i,
  input  logic [AW-1:0]     wr_addr_i,
  input  logic [WORD_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [AW-1:0]     rd_addr_i,
  output logic [WORD_W-1:0] rd_data_o
);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] rd_data_q;

  always_ff @(posedge clk_sys) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  // Read-before-write: a same-edge push to the popped slot returns the old word.
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) rd_data_q <= '0;
    else if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/rx_word_fifo.sv
// Packs received bytes into little-endian words, buffers them, and serves them to the
// loader through a request/ack handshake. Partial words are flushed after an idle timeout.
module rx_word_fifo
  import ram_loader_pkg::*;
#(
  parameter int DEPTH          = 16,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                     clk_sys,
  input  logic                     rst_sys_n,
  input  logic [BYTE_W-1:0]        rx_data_i,
  input  logic                     rx_valid_i,
  input  logic                     clear_i,
  input  logic                     read_enable_i,
  output logic [WORD_W-1:0]        data_o,
  output logic                     rx_ack_o,
  output logic                     empty_no,
  output logic                     full_o,
  output logic                     overflow_o,
  output logic [$clog2(DEPTH):0]   word_cnt_o
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;
  localparam int IDX_W = $clog2(BYTES_PER_WORD);
  localparam int ACC_W = (BYTES_PER_WORD - 1) * BYTE_W;
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic [IDX_W-1:0] byte_idx_q;
  logic [ACC_W-1:0] acc_q;
  logic [TMO_W-1:0] tmo_q;
  logic             ovf_q;
  logic             ack_q;
  rd_state_e        state_q;

  logic              word_done, flush, push_req, push_ok, pop;
  logic [WORD_W-1:0] push_word;

  assign word_done = rx_valid_i && (byte_idx_q == LAST_IDX);
  // A byte on the terminal edge wins over the flush, so the flush requires !rx_valid_i.
  assign flush     = (TIMEOUT_CYCLES != 0) && !rx_valid_i && (byte_idx_q != '0) &&
                     (tmo_q == TMO_W'(TIMEOUT_CYCLES));
  assign push_req  = !clear_i && (word_done || flush);
  assign pop       = !clear_i && (state_q == IDLE) && read_enable_i && (count_q != '0);
  assign push_ok   = push_req && ((count_q != CW'(DEPTH)) || pop);
  // acc_q is zeroed after every push, so unused upper lanes of a flushed word are already 0.
  assign push_word = word_done ? {rx_data_i, acc_q} : {{BYTE_W{1'b0}}, acc_q};

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      byte_idx_q <= '0;
      acc_q      <= '0;
      tmo_q      <= '0;
    end else if (clear_i) begin
      byte_idx_q <= '0;
      acc_q      <= '0;
      tmo_q      <= '0;
    end else if (rx_valid_i) begin
      tmo_q <= '0;
      if (byte_idx_q == LAST_IDX) begin
        byte_idx_q <= '0;
        acc_q      <= '0;
      end else begin
        byte_idx_q <= byte_idx_q + IDX_W'(1);
        for (int k = 0; k < BYTES_PER_WORD - 1; k++) begin
          if (byte_idx_q == IDX_W'(k)) acc_q[k*BYTE_W +: BYTE_W] <= rx_data_i;
        end
      end
    end else if (flush) begin
      byte_idx_q <= '0;
      acc_q      <= '0;
      tmo_q      <= '0;
    end else if ((byte_idx_q != '0) && (TIMEOUT_CYCLES != 0)) begin
      tmo_q <= tmo_q + TMO_W'(1);
    end
  end

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      if (push_req && !push_ok) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
    end else if (clear_i) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          ack_q <= pop;
          if (pop) state_q <= ACK;
        end
        ACK: begin
          ack_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          ack_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  fifo_mem #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_mem (
    .clk_sys  (clk_sys),
    .rst_sys_n(rst_sys_n),
    .wr_en_i  (push_ok),
    .wr_addr_i(wr_ptr_q),
    .wr_data_i(push_word),
    .rd_en_i  (pop),
    .rd_addr_i(rd_ptr_q),
    .rd_data_o(data_o)
  );

  assign rx_ack_o   = ack_q;
  assign empty_no   = (count_q != '0);
  assign full_o     = (count_q == CW'(DEPTH));
  assign overflow_o = ovf_q;
  assign word_cnt_o = count_q;

endmodule

// File: tb/tb_rx_word_fifo.sv
// Directed scenarios plus a randomized run, checked every cycle against a queue-based model.
module tb_rx_word_fifo;
  localparam int DEPTH = 16;
  localparam int TMO   = 8;

  logic        clk_sys = 1'b0;
  logic        rst_sys_n = 1'b0;
  logic [7:0]  rx_data_i = '0;
  logic        rx_valid_i = 1'b0;
  logic        clear_i = 1'b0;
  logic        read_enable_i = 1'b0;
  logic [31:0] data_o;
  logic        rx_ack_o, empty_no, full_o, overflow_o;
  logic [4:0]  word_cnt_o;

  rx_word_fifo #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_sys      (clk_sys),
    .rst_sys_n    (rst_sys_n),
    .rx_data_i    (rx_data_i),
    .rx_valid_i   (rx_valid_i),
    .clear_i      (clear_i),
    .read_enable_i(read_enable_i),
    .data_o       (data_o),
    .rx_ack_o     (rx_ack_o),
    .empty_no     (empty_no),
    .full_o       (full_o),
    .overflow_o   (overflow_o),
    .word_cnt_o   (word_cnt_o)
  );

  always #5 clk_sys = ~clk_sys;

  int checks = 0;
  int errors = 0;
  int acks   = 0;

  // Reference model: stored words, bytes of the word being collected, idle time.
  logic [31:0] m_q[$];
  logic [7:0]  m_part[$];
  int          m_idle = 0;
  bit          m_ovf  = 0;
  bit          m_ack  = 0;
  logic [31:0] m_data = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s at %0t: observed=%h expected=%h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_part.delete();
    m_idle = 0;
    m_ovf  = 0;
    m_ack  = 0;
    m_data = '0;
  endtask

  task automatic model_step(input bit v, input logic [7:0] d, input bit ren, input bit clr);
    bit          pop, have;
    int          sz;
    logic [31:0] w;
    if (clr) begin
      m_q.delete();
      m_part.delete();
      m_idle = 0;
      m_ovf  = 0;
      m_ack  = 0;
      return;
    end
    pop  = !m_ack && ren && (m_q.size() > 0);
    have = 0;
    w    = '0;
    if (v) begin
      m_part.push_back(d);
      m_idle = 0;
    end else if (m_part.size() > 0) begin
      if (m_idle == TMO) begin
        have   = 1;
        m_idle = 0;
      end else begin
        m_idle++;
      end
    end
    if (m_part.size() == 4) have = 1;
    if (have) begin
      for (int i = 0; i < m_part.size(); i++) w = w | (32'(m_part[i]) << (8 * i));
      m_part.delete();
    end
    sz = m_q.size();
    if (pop) m_data = m_q.pop_front();
    if (have) begin
      if (sz < DEPTH || pop) m_q.push_back(w);
      else m_ovf = 1;
    end
    m_ack = pop;
  endtask

  task automatic check_all();
    chk("data_o", data_o, m_data);
    chk("rx_ack_o", 32'(rx_ack_o), 32'(m_ack));
    chk("empty_no", 32'(empty_no), 32'(m_q.size() != 0));
    chk("full_o", 32'(full_o), 32'(m_q.size() == DEPTH));
    chk("overflow_o", 32'(overflow_o), 32'(m_ovf));
    chk("word_cnt_o", 32'(word_cnt_o), 32'(m_q.size()));
  endtask

  task automatic cyc(input bit v, input logic [7:0] d, input bit ren, input bit clr);
    rx_valid_i    = v;
    rx_data_i     = d;
    read_enable_i = ren;
    clear_i       = clr;
    @(posedge clk_sys);
    model_step(v, d, ren, clr);
    #1;
    check_all();
    if (rx_ack_o) acks++;
  endtask

  task automatic idle(input int n, input bit ren);
    for (int i = 0; i < n; i++) cyc(0, 8'h00, ren, 0);
  endtask

  task automatic send_word(input logic [31:0] w, input bit ren);
    for (int i = 0; i < 4; i++) cyc(1, w[8*i +: 8], ren, 0);
  endtask

  task automatic async_reset();
    #2;
    rst_sys_n = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge clk_sys);
    rx_valid_i = 0; read_enable_i = 0; clear_i = 0;
    @(negedge clk_sys);
    rst_sys_n = 1'b1;
  endtask

  initial begin
    logic [31:0] w;
    bit          v, ren, clr;
    int          wr_heavy;

    #1;
    model_reset();
    check_all();
    @(negedge clk_sys);
    rst_sys_n = 1'b1;

    // Basic pack and read
    cyc(1, 8'h11, 0, 0); cyc(1, 8'h22, 0, 0); cyc(1, 8'h33, 0, 0); cyc(1, 8'h44, 0, 0);
    cyc(0, 8'h00, 1, 0);
    chk("basic_word", data_o, 32'h44332211);
    chk("basic_ack", 32'(rx_ack_o), 32'd1);
    idle(2, 0);
    chk("basic_cnt", 32'(word_cnt_o), 32'd0);

    // Fill and overflow
    for (int i = 0; i < DEPTH + 1; i++) send_word($urandom, 0);
    chk("fill_full", 32'(full_o), 32'd1);
    chk("fill_ovf", 32'(overflow_o), 32'd1);
    idle(2 * DEPTH + 6, 1);
    chk("drain_cnt", 32'(word_cnt_o), 32'd0);

    // Timeout flush, then cancellation by a late byte
    cyc(0, 8'h00, 0, 1);
    cyc(1, 8'hAA, 0, 0); cyc(1, 8'hBB, 0, 0);
    idle(12, 0);
    chk("tmo_cnt", 32'(word_cnt_o), 32'd1);
    cyc(0, 8'h00, 1, 0);
    chk("tmo_word", data_o, 32'h0000BBAA);
    idle(1, 0);
    cyc(1, 8'h01, 0, 0); cyc(1, 8'h02, 0, 0);
    idle(6, 0);
    cyc(1, 8'h03, 0, 0);
    chk("tmo_cancel", 32'(word_cnt_o), 32'd0);
    idle(12, 0);
    cyc(0, 8'h00, 1, 0);
    chk("tmo_word3", data_o, 32'h00030201);
    idle(1, 0);

    // Request while empty: one ack only
    acks = 0;
    idle(5, 1);
    chk("empty_noack", 32'(acks), 32'd0);
    send_word(32'hCAFEF00D, 1);
    idle(5, 1);
    chk("empty_one_ack", 32'(acks), 32'd1);
    chk("empty_word", data_o, 32'hCAFEF00D);
    idle(1, 0);

    // Simultaneous push and pop at full
    for (int i = 0; i < DEPTH; i++) send_word($urandom, 0);
    cyc(1, 8'h5A, 0, 0); cyc(1, 8'h6B, 0, 0); cyc(1, 8'h7C, 0, 0);
    cyc(1, 8'h8D, 1, 0);
    chk("simul_cnt", 32'(word_cnt_o), 32'd16);
    chk("simul_ovf", 32'(overflow_o), 32'd0);
    idle(2 * DEPTH + 4, 1);

    // Clear mid-operation
    for (int i = 0; i < 5; i++) send_word($urandom, 0);
    cyc(1, 8'hE1, 0, 0); cyc(1, 8'hE2, 0, 0);
    cyc(0, 8'h00, 0, 1);
    chk("clear_cnt", 32'(word_cnt_o), 32'd0);
    send_word(32'h0BADBEEF, 0);
    cyc(0, 8'h00, 1, 0);
    chk("clear_word", data_o, 32'h0BADBEEF);
    idle(1, 0);

    // Reset mid-word and in ACK
    send_word($urandom, 0);
    send_word($urandom, 0);
    cyc(1, 8'hD1, 0, 0); cyc(1, 8'hD2, 0, 0);
    cyc(0, 8'h00, 1, 0);
    async_reset();
    chk("rst_data", data_o, 32'd0);
    send_word(32'h87654321, 0);
    cyc(0, 8'h00, 1, 0);
    chk("rst_word", data_o, 32'h87654321);
    idle(1, 0);

    // Randomized run
    wr_heavy = 1;
    for (int n = 0; n < 4000; n++) begin
      if (n % 250 == 0) wr_heavy = $urandom_range(0, 1);
      if ($urandom_range(0, 59) == 0) idle($urandom_range(5, 14), $urandom_range(0, 1));
      v   = wr_heavy ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 3);
      ren = wr_heavy ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 9) < 8);
      clr = ($urandom_range(0, 499) == 0);
      w   = $urandom;
      cyc(v, w[7:0], ren, clr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
